// File: rtl/branch_skip_sequencer_pkg.sv
// Shared definitions for the branch skip sequencer and its depth counter.
// The optional overflow check is enabled with the BRANCH_SKIP_OVF_CHECK_EN macro.
// That macro adds the SKIP_ERR state to skip_state_t.
package definitions;

  // Default width of the bracket nesting-depth counter.
  localparam int SKIP_DEPTH_W = 8;

  // Core opcode set. CBF and CBB are the forward and backward conditional branches.
  typedef enum logic [3:0] {
    NOP,
    INC,
    DEC,
    MVR,
    MVL,
    INP,
    OUT,
    CBF,
    CBB
  } op_code;

`ifdef BRANCH_SKIP_OVF_CHECK_EN
  typedef enum logic [1:0] {
    SKIP_IDLE,
    SKIP_SCAN,
    SKIP_DONE,
    SKIP_ERR
  } skip_state_t;
`else
  typedef enum logic [1:0] {
    SKIP_IDLE,
    SKIP_SCAN,
    SKIP_DONE
  } skip_state_t;
`endif

endpackage

// File: rtl/branch_skip_sequencer_depth.sv
// Bracket nesting-depth counter for the branch skip sequencer.
// It supports load-to-1, increment and decrement.
// dec_to_zero flags a decrement that reaches zero.
// With BRANCH_SKIP_OVF_CHECK_EN, ovf flags an increment at the maximum depth,
// and the count saturates there instead of wrapping.
module skip_depth_counter
  import definitions::*;
#(
  parameter int DEPTH_W = SKIP_DEPTH_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] count,
`ifdef BRANCH_SKIP_OVF_CHECK_EN
  output logic               ovf,
`endif
  output logic               dec_to_zero
);

  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;

  // The matching CBB is the one that takes the depth from 1 to 0.
  assign dec_to_zero = dec && (count == ONE);

`ifdef BRANCH_SKIP_OVF_CHECK_EN
  assign ovf = inc && (count == MAX_DEPTH);
`endif

  // Depth register: reset clears it, a new skip loads it with 1, and CBF/CBB step it.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= ONE;
    end else if (inc) begin
`ifdef BRANCH_SKIP_OVF_CHECK_EN
      if (!ovf) count <= count + ONE;
`else
      count <= count + ONE;
`endif
    end else if (dec) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/branch_skip_sequencer.sv
// Branch skip sequencer. When a forward branch (CBF) is not taken, it walks the
// instruction stream up to the matching CBB.
// While busy, it owns fetch_req and pc_advance.
// The optional overflow check (SKIP_ERR state and sticky error output) is
// enabled with the BRANCH_SKIP_OVF_CHECK_EN macro.
module branch_skip_sequencer
  import definitions::*;
#(
  parameter int DEPTH_W = SKIP_DEPTH_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_skip,
  input  op_code             instruction,
  input  logic               instr_valid,
  output logic               fetch_req,
  output logic               pc_advance,
  output logic               busy,
  output logic               done,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);

  skip_state_t state;
  logic        accept;
  logic        load;
  logic        inc;
  logic        dec;
  logic        dec_to_zero;
`ifdef BRANCH_SKIP_OVF_CHECK_EN
  logic        ovf;
`endif

  // An instruction is consumed only while scanning. The PC advances in the same cycle.
  assign accept     = (state == SKIP_SCAN) && instr_valid;
  assign load       = (state == SKIP_IDLE) && start_skip;
  assign inc        = accept && (instruction == CBF);
  assign dec        = accept && (instruction == CBB);
  assign pc_advance = accept;

  skip_depth_counter #(
    .DEPTH_W(DEPTH_W)
  ) u_depth (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .inc        (inc),
    .dec        (dec),
    .count      (depth),
`ifdef BRANCH_SKIP_OVF_CHECK_EN
    .ovf        (ovf),
`endif
    .dec_to_zero(dec_to_zero)
  );

`ifndef BRANCH_SKIP_OVF_CHECK_EN
  assign error = 1'b0;
`endif

  // Skip FSM with registered fetch_req, busy, done and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SKIP_IDLE;
      fetch_req <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BRANCH_SKIP_OVF_CHECK_EN
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        SKIP_IDLE: begin
          if (start_skip) begin
            state     <= SKIP_SCAN;
            fetch_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SKIP_SCAN: begin
`ifdef BRANCH_SKIP_OVF_CHECK_EN
          if (ovf) begin
            state     <= SKIP_ERR;
            fetch_req <= 1'b0;
            error     <= 1'b1;
          end else
`endif
          if (dec_to_zero) begin
            state     <= SKIP_DONE;
            fetch_req <= 1'b0;
            done      <= 1'b1;
          end
        end
        SKIP_DONE: begin
          state <= SKIP_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
`ifdef BRANCH_SKIP_OVF_CHECK_EN
        // Stay stalled with the error flagged until reset.
        SKIP_ERR: begin
          state <= SKIP_ERR;
        end
`endif
        default: begin
          state     <= SKIP_IDLE;
          fetch_req <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
